// File: rtl/cnn_pkg.sv
// cnn_pkg: shared state encoding, bank constants and width helper for the CNN sequencing blocks.
package cnn_pkg;

    typedef enum logic [2:0] {IDLE, ARM, RUN, SWAP, FINISH, ERR} conv_sched_state_t;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    function automatic int clog2_min1(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_scheduler_if.sv
// conv_scheduler_if: handshake between the scheduler, the host loader and the convolution engine.
interface conv_sched_if
    import cnn_pkg::*;
#(
    parameter int NUM_PASSES = 4
) ();
    localparam int PW = clog2_min1(NUM_PASSES);

    logic          layer_start;
    logic          host_req;
    logic          host_gnt;
    logic          conv_start;
    logic          conv_done;
    logic [PW-1:0] pass_idx;
    logic          rd_bank;
    logic          wr_bank;
    logic          busy;
    logic          layer_done;
    logic          timeout_err;

    modport master (
        output layer_start, host_req, conv_done,
        input  host_gnt, conv_start, pass_idx, rd_bank, wr_bank, busy, layer_done, timeout_err
    );

    modport slave (
        input  layer_start, host_req, conv_done,
        output host_gnt, conv_start, pass_idx, rd_bank, wr_bank, busy, layer_done, timeout_err
    );

endinterface

// File: rtl/conv_scheduler_watchdog_counter.sv
// watchdog_counter: counts enabled cycles and flags when the count sits at LIMIT-1.
module watchdog_counter
    import cnn_pkg::*;
#(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = clog2_min1(LIMIT);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = clr ? '0 : en ? count_q + 1'b1 : count_q;
        expired = count_q == W'(LIMIT - 1);
    end

    always_ff @(posedge clk) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

endmodule

// File: rtl/conv_scheduler.sv
// conv_scheduler: runs NUM_PASSES convolution passes per layer, ping-pongs the feature-RAM banks
// between passes and hands the feature RAM to the host loader only while idle.
module conv_scheduler
    import cnn_pkg::*;
#(
    parameter int NUM_PASSES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic         clk,
    input logic         rst,
    conv_sched_if.slave bus
);
    localparam int            PW        = clog2_min1(NUM_PASSES);
    localparam logic [PW-1:0] LAST_PASS = PW'(NUM_PASSES - 1);

    conv_sched_state_t state_q;
    logic              pending_q, pending_d, launch;
    logic              host_gnt_q, conv_start_q, busy_q, layer_done_q, timeout_err_q, rd_bank_q;
    logic              wd_expired;
    logic [PW-1:0]     pass_idx_q;

    // The host wins: a layer only launches once both the request and the grant are low.
    always_comb begin
        launch    = state_q == IDLE && (pending_q || bus.layer_start) && !bus.host_req && !host_gnt_q;
        pending_d = (pending_q || (bus.layer_start && (state_q == IDLE || state_q == ERR))) && !launch;
    end

    watchdog_counter #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == ARM),
        .en     (state_q == RUN),
        .expired(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            pending_q     <= 1'b0;
            host_gnt_q    <= 1'b0;
            conv_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            layer_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            rd_bank_q     <= BANK_A;
            pass_idx_q    <= '0;
        end else begin
            pending_q    <= pending_d;
            conv_start_q <= 1'b0;
            layer_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    host_gnt_q <= bus.host_req;
                    if (launch) begin
                        state_q       <= ARM;
                        conv_start_q  <= 1'b1;
                        busy_q        <= 1'b1;
                        timeout_err_q <= 1'b0;
                    end
                end
                ARM: state_q <= RUN;
                // Completion beats the watchdog when both land in the same cycle.
                RUN: begin
                    if (bus.conv_done) begin
                        state_q <= SWAP;
                    end else if (wd_expired) begin
                        state_q       <= ERR;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                        pass_idx_q    <= '0;
                    end
                end
                SWAP: begin
                    rd_bank_q <= ~rd_bank_q;
                    if (pass_idx_q == LAST_PASS) begin
                        state_q      <= FINISH;
                        layer_done_q <= 1'b1;
                    end else begin
                        state_q      <= ARM;
                        conv_start_q <= 1'b1;
                        pass_idx_q   <= pass_idx_q + 1'b1;
                    end
                end
                FINISH: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    pass_idx_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.host_gnt    = host_gnt_q;
        bus.conv_start  = conv_start_q;
        bus.busy        = busy_q;
        bus.layer_done  = layer_done_q;
        bus.timeout_err = timeout_err_q;
        bus.pass_idx    = pass_idx_q;
        bus.rd_bank     = rd_bank_q;
        bus.wr_bank     = ~rd_bank_q;
    end

endmodule

// File: tb/tb_conv_scheduler.sv
// tb_conv_scheduler: scoreboard bench; stimulus predicts start/done/timeout events from the timing rules.
module tb_conv_scheduler;
    import cnn_pkg::*;

    localparam int N = 4;
    localparam int T = 16;

    typedef struct {
        int   kind;
        int   cyc;
        int   pass;
        logic bank;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic bank = BANK_A;
    logic prev_to = 1'b0;
    exp_t q[$];
    int   dq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_sched_if #(.NUM_PASSES(N)) bus ();

    conv_scheduler #(.NUM_PASSES(N), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step();
        goto(cyc + 1);
    endtask

    function automatic void push(input int kind, input int c, input int pass, input logic b);
        q.push_back('{kind, c, pass, b});
    endfunction

    // kind: 0 conv_start, 1 layer_done, 2 timeout_err rising
    always @(negedge clk) begin
        int   k;
        exp_t e;
        if (rst && (bus.conv_start || bus.layer_done || (bus.timeout_err && !prev_to))) begin
            k = bus.conv_start ? 0 : bus.layer_done ? 1 : 2;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: kind %0d at cycle %0d, expected no event", k, cyc);
            end else begin
                e = q.pop_front();
                check("event_kind", k, e.kind);
                check("event_cycle", cyc, e.cyc);
                if (k != 2) check("event_rd_bank", int'(bus.rd_bank), int'(e.bank));
                if (k == 0) begin
                    check("start_pass_idx", int'(bus.pass_idx), e.pass);
                    check("start_wr_bank", int'(bus.wr_bank), int'(!e.bank));
                    check("start_timeout_clr", int'(bus.timeout_err), 0);
                    check("start_busy", int'(bus.busy), 1);
                end
                if (k == 2) check("err_busy", int'(bus.busy), 0);
            end
        end
        prev_to = bus.timeout_err;
    end

    task automatic run_layer(input int hold, output bit tout);
        int s, d, n, c0;
        c0   = cyc;
        tout = 1'b0;
        if (hold > 0) begin
            bus.host_req    = 1'b1;
            bus.layer_start = 1'b1;
            step();
            bus.layer_start = 1'b0;
            check("host_gnt_on", int'(bus.host_gnt), 1);
            goto(c0 + hold);
            bus.host_req = 1'b0;
            step();
            check("host_gnt_off", int'(bus.host_gnt), 0);
            s = c0 + hold + 2;
        end else begin
            bus.layer_start = 1'b1;
            step();
            bus.layer_start = 1'b0;
            s = c0 + 1;
        end
        push(0, s, 0, bank);
        for (int p = 0; p < N; p++) begin
            d = dq.size() > 0 ? dq.pop_front() : int'($urandom_range(1, T + 2));
            if (d > T) begin
                push(2, s + T + 1, 0, bank);
                goto(s + T + 2);
                check("err_idle_busy", int'(bus.busy), 0);
                check("err_pass_idx", int'(bus.pass_idx), 0);
                tout = 1'b1;
                return;
            end
            if (d >= 2 && $urandom_range(0, 1) == 1) begin
                n = s + 1 + int'($urandom_range(0, d - 2));
                goto(n);
                bus.layer_start = 1'b1;
                step();
                bus.layer_start = 1'b0;
            end
            goto(s + d);
            bus.conv_done = 1'b1;
            step();
            bus.conv_done = 1'b0;
            bank = ~bank;
            if (p == N - 1) begin
                push(1, s + d + 2, 0, bank);
                goto(s + d + 3);
                check("idle_busy", int'(bus.busy), 0);
                check("idle_pass_idx", int'(bus.pass_idx), 0);
                check("idle_rd_bank", int'(bus.rd_bank), int'(bank));
                return;
            end
            s = s + d + 2;
            push(0, s, p + 1, bank);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c0, s;
        bit tout;
        bus.layer_start = 1'b0;
        bus.host_req    = 1'b0;
        bus.conv_done   = 1'b0;
        goto(2);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_conv_start", int'(bus.conv_start), 0);
        check("rst_host_gnt", int'(bus.host_gnt), 0);
        check("rst_layer_done", int'(bus.layer_done), 0);
        check("rst_timeout_err", int'(bus.timeout_err), 0);
        check("rst_pass_idx", int'(bus.pass_idx), 0);
        check("rst_rd_bank", int'(bus.rd_bank), 0);
        check("rst_wr_bank", int'(bus.wr_bank), 1);
        rst = 1'b1;
        goto(4);

        dq = '{11, 11, 11, 11};
        run_layer(0, tout);
        goto(cyc + 2);
        run_layer(20, tout);
        goto(cyc + 2);

        dq = '{T + 1};
        run_layer(0, tout);
        goto(cyc + 3);
        check("timeout_sticky", int'(bus.timeout_err), 1);
        dq = '{T, 1, T, 2};
        run_layer(0, tout);
        check("timeout_cleared", int'(bus.timeout_err), 0);

        bus.conv_done = 1'b1;
        step();
        bus.conv_done = 1'b0;
        goto(cyc + 3);
        check("idle_done_ignored", int'(bus.busy), 0);
        run_layer(0, tout);
        goto(cyc + 2);

        c0 = cyc;
        bus.layer_start = 1'b1;
        step();
        bus.layer_start = 1'b0;
        s = c0 + 1;
        push(0, s, 0, bank);
        for (int p = 0; p < 2; p++) begin
            goto(s + 11);
            bus.conv_done = 1'b1;
            step();
            bus.conv_done = 1'b0;
            bank = ~bank;
            s += 13;
            push(0, s, p + 1, bank);
        end
        goto(s + 5);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_conv_start", int'(bus.conv_start), 0);
        check("midrst_layer_done", int'(bus.layer_done), 0);
        check("midrst_pass_idx", int'(bus.pass_idx), 0);
        check("midrst_rd_bank", int'(bus.rd_bank), 0);
        check("midrst_wr_bank", int'(bus.wr_bank), 1);
        check("midrst_host_gnt", int'(bus.host_gnt), 0);
        bank = BANK_A;
        goto(s + 8);
        bus.conv_done = 1'b1;
        step();
        bus.conv_done = 1'b0;
        goto(s + 12);
        check("midrst_done_ignored", int'(bus.busy), 0);

        repeat (25) begin
            goto(cyc + int'($urandom_range(0, 4)));
            if ($urandom_range(0, 3) == 0) begin
                bus.conv_done = 1'b1;
                step();
                bus.conv_done = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) begin
                bus.host_req = 1'b1;
                step();
                check("host_only_gnt_on", int'(bus.host_gnt), 1);
                goto(cyc + int'($urandom_range(0, 3)));
                bus.host_req = 1'b0;
                step();
                check("host_only_gnt_off", int'(bus.host_gnt), 0);
            end
            run_layer($urandom_range(0, 2) == 0 ? int'($urandom_range(2, 6)) : 0, tout);
        end

        goto(cyc + 5);
        check("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
